spd_traceback: RTL and testbench

SPD_TRACEBACK -- requirements
Module: spd_traceback

---
 rtl/spd_pkg.sv | 16 +
 rtl/pm_argmin.sv | 39 +++
 rtl/spd_traceback.sv | 162 ++++++++++++++++
 tb/tb_spd_traceback.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spd_pkg.sv
// Shared defaults and FSM encoding for the Viterbi survivor-path traceback.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spd_pkg;

  localparam int SPD_NUM_STATES = 4;
  localparam int SPD_PM_W       = 4;
  localparam int SPD_TB_DEPTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } tb_state_t;

endpackage

// File: rtl/pm_argmin.sv
// Index of the smallest path metric; ties go to the lowest state index.
// Latency: combinational.
// Backpressure: none.
module pm_argmin
  import spd_pkg::*;
#(
  parameter int NUM_STATES = SPD_NUM_STATES,
  parameter int PM_W       = SPD_PM_W,
  localparam int M         = $clog2(NUM_STATES)
) (
  input  logic [NUM_STATES*PM_W-1:0] pm,
  output logic [M-1:0]               idx
);

  // Heap-ordered tree: node n has children 2n (lower indices) and 2n+1.
  logic [PM_W-1:0] node_pm  [2*NUM_STATES];
  logic [M-1:0]    node_idx [2*NUM_STATES];

  // Leaves hold the metrics; each parent keeps the left child unless the right is strictly smaller.
  always_comb begin
    node_pm[0]  = '0;
    node_idx[0] = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      node_pm[NUM_STATES+s]  = pm[s*PM_W +: PM_W];
      node_idx[NUM_STATES+s] = M'(s);
    end
    for (int n = NUM_STATES - 1; n >= 1; n--) begin
      if (node_pm[2*n+1] < node_pm[2*n]) begin
        node_pm[n]  = node_pm[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end else begin
        node_pm[n]  = node_pm[2*n];
        node_idx[n] = node_idx[2*n];
      end
    end
    idx = node_idx[1];
  end

endmodule

// File: rtl/spd_traceback.sv
// Survivor-memory ring plus traceback FSM; emits one decoded bit per full-ring write.
// Latency: out_valid arrives TB_DEPTH+1 cycles after the triggering write.
// Backpressure: in_ready drops for the whole traceback. Optional SPD_FLUSH_EN adds a flush drain.
module spd_traceback
  import spd_pkg::*;
#(
  parameter int NUM_STATES = SPD_NUM_STATES,
  parameter int PM_W       = SPD_PM_W,
  parameter int TB_DEPTH   = SPD_TB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_STATES-1:0]      dec,
  input  logic [NUM_STATES*PM_W-1:0] pm,
`ifdef SPD_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       out,
  output logic                       out_valid
);

  localparam int M  = $clog2(NUM_STATES);
  localparam int CW = $clog2(TB_DEPTH);
  localparam int NW = $clog2(TB_DEPTH + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(TB_DEPTH - 1);
  localparam logic [NW-1:0] FULL     = NW'(TB_DEPTH);

  tb_state_t             state;
  logic [NUM_STATES-1:0] mem [TB_DEPTH];
  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         col;
  logic [CW-1:0]         steps;
  logic [NW-1:0]         count;
  logic [M-1:0]          tstate;
  logic [M-1:0]          best;
  logic                  wr;
  logic [CW-1:0]         wr_ptr_nxt;
  logic [NW-1:0]         count_nxt;

  assign wr         = in_valid && in_ready;
  assign wr_ptr_nxt = (wr_ptr == LAST_COL) ? '0 : wr_ptr + 1'b1;
  assign count_nxt  = (count == FULL) ? FULL : count + 1'b1;

  pm_argmin #(
    .NUM_STATES (NUM_STATES),
    .PM_W       (PM_W)
  ) u_argmin (
    .pm  (pm),
    .idx (best)
  );

`ifdef SPD_FLUSH_EN
  // drain: a flush is pending; drain_run: the current traceback retires a column.
  logic          drain;
  logic          drain_run;
  logic [M-1:0]  start_st;
  logic [CW-1:0] newest;
  assign newest = (wr_ptr == '0) ? LAST_COL : wr_ptr - 1'b1;
`endif

  // Survivor memory: one decision column per accepted write, no reset needed.
  always_ff @(posedge clk) begin
    if (wr && !reset) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Ring pointers, traceback walk and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      col       <= '0;
      steps     <= '0;
      tstate    <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SPD_FLUSH_EN
      drain     <= 1'b0;
      drain_run <= 1'b0;
      start_st  <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef SPD_FLUSH_EN
          if (drain) begin
            if (count == '0) begin
              drain    <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              // Drain pass: walk count-1 columns back from the newest one.
              drain_run <= 1'b1;
              tstate    <= start_st;
              col       <= newest;
              steps     <= CW'(count - 1'b1);
              state     <= (count == NW'(1)) ? EMIT : TRACE;
            end
          end else
`endif
          if (wr) begin
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
            tstate <= best;
            col    <= wr_ptr;
            steps  <= LAST_COL;
`ifdef SPD_FLUSH_EN
            start_st <= best;
`endif
            if (count_nxt == FULL) begin
              state    <= TRACE;
              in_ready <= 1'b0;
            end
          end
`ifdef SPD_FLUSH_EN
          if (!drain && flush && (wr || count != '0)) begin
            drain    <= 1'b1;
            in_ready <= 1'b0;
          end
`endif
        end
        TRACE: begin
          tstate <= {tstate[M-2:0], mem[col][tstate]};
          col    <= (col == '0) ? LAST_COL : col - 1'b1;
          steps  <= steps - 1'b1;
          if (steps == CW'(1)) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          out       <= tstate[M-1];
          out_valid <= 1'b1;
          state     <= IDLE;
          in_ready  <= 1'b1;
`ifdef SPD_FLUSH_EN
          drain_run <= 1'b0;
          if (drain_run) begin
            count <= count - 1'b1;
            if (count == NW'(1)) begin
              drain <= 1'b0;
            end else begin
              in_ready <= 1'b0;
            end
          end else if (drain) begin
            in_ready <= 1'b0;
          end
`endif
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spd_traceback.sv
// Scoreboard bench for spd_traceback: stimulus pushes expected bits, a monitor pops on out_valid.
// Latency: n/a.
// Backpressure: writes wait on in_ready with a bounded loop.
module tb_spd_traceback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  dec = '0;
  logic [15:0] pm = '0;
  logic        out;
  logic        out_valid;
`ifdef SPD_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q [$];

  int          bits [16] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0};
  logic [3:0]  s_dec [16];
  logic [15:0] s_pm [16];

  always #5 clk = ~clk;

  spd_traceback #(
    .NUM_STATES (4),
    .PM_W       (4),
    .TB_DEPTH   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dec       (dec),
    .pm        (pm),
`ifdef SPD_FLUSH_EN
    .flush     (flush),
`endif
    .out       (out),
    .out_valid (out_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_col(input logic [3:0] d, input logic [15:0] p);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL write_wait: in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      dec      = d;
      pm       = p;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Hard-decision ACS for the (7,5) K=3 code, noiseless channel, known zero start state.
  task automatic build_stream();
    int metric [4];
    int nm [4];
    int st, u, a, b, r0, r1, c0, c1, mn;
    metric = '{0, 8, 8, 8};
    st = 0;
    for (int t = 0; t < 16; t++) begin
      u  = bits[t];
      a  = (st >> 1) & 1;
      b  = st & 1;
      r0 = u ^ a ^ b;
      r1 = u ^ b;
      st = (u << 1) | a;
      for (int n = 0; n < 4; n++) begin
        int nu, na;
        nu = (n >> 1) & 1;
        na = n & 1;
        c0 = metric[na*2+0] + (((nu ^ na) != r0) ? 1 : 0) + ((nu != r1) ? 1 : 0);
        c1 = metric[na*2+1] + (((nu ^ na ^ 1) != r0) ? 1 : 0) + (((nu ^ 1) != r1) ? 1 : 0);
        s_dec[t][n] = (c1 < c0);
        nm[n] = (c1 < c0) ? c1 : c0;
      end
      mn = nm[0];
      for (int n = 1; n < 4; n++) if (nm[n] < mn) mn = nm[n];
      for (int n = 0; n < 4; n++) begin
        metric[n] = nm[n] - mn;
        if (metric[n] > 15) metric[n] = 15;
        s_pm[t][n*4 +: 4] = 4'(metric[n]);
      end
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  initial begin
    logic e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: out_valid=1 out=%0d with nothing expected", out);
        end else begin
          e = exp_q.pop_front();
          check("out_bit", out, e);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d failed %0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int early, low, pulses;

    // Reset state and quiet idle period.
    do_reset();
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rst_idle_pulses", pulses, 0);

    // Eight zero-decision columns, state 0 best; ignored input during the busy window.
    early = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(1'b0);
      write_col(4'b0000, 16'h5550);
      if (i < 7 && !in_ready) early++;
    end
    check("no_trigger_before_full", early, 0);
    low   = 0;
    early = 0;
    for (int k = 1; k <= 8; k++) begin
      if (!in_ready) low++;
      if (out_valid) early++;
      if (k == 1) begin
        dec      = 4'b1111;
        pm       = 16'h0555;
        in_valid = 1'b1;
      end
      if (k == 8) in_valid = 1'b0;
      @(negedge clk);
    end
    check("busy_in_ready_low", low, 8);
    check("busy_no_early_pulse", early, 0);
    check("emit_cycle9_valid", out_valid, 1);
    check("emit_cycle9_ready", in_ready, 1);
    exp_q.push_back(1'b0);
    write_col(4'b0000, 16'h5550);
    wait_drain("drain_zero_cols");

    // Equal metrics must start at state 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(1'b0);
      write_col(4'b1010, 16'h3333);
    end
    wait_drain("drain_tie");

    // All-ones decisions from state 2 settle in state 3; then one overwrite from state 1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(1'b1);
      write_col(4'b1111, 16'h5055);
    end
    exp_q.push_back(1'b1);
    write_col(4'b0000, 16'h5505);
    wait_drain("drain_ones");

    // Noiseless coded stream: decoded bits lag the input by seven columns.
    build_stream();
    do_reset();
    for (int w = 0; w < 16; w++) begin
      if (w >= 7) exp_q.push_back(bits[w-7][0]);
      write_col(s_dec[w], s_pm[w]);
    end
    wait_drain("drain_stream");

    // Reset on the third traceback cycle aborts it; ring restarts empty.
    do_reset();
    for (int i = 0; i < 8; i++) write_col(4'b0000, 16'h5550);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    repeat (12) @(negedge clk);
    early = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(1'b1);
      write_col(4'b1111, 16'h5055);
      if (i < 7 && !in_ready) early++;
    end
    check("abort_count_restart", early, 0);
    wait_drain("drain_after_abort");

`ifdef SPD_FLUSH_EN
    // Three columns then flush: oldest-first decode 0,0,1 with in_ready low until the last.
    do_reset();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) write_col(4'b0000, 16'h5055);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    pulses = 0;
    early  = 0;
    for (int k = 0; k < 60 && pulses < 3; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (pulses < 3 && in_ready) early++;
    end
    check("flush_pulses", pulses, 3);
    check("flush_ready_low", early, 0);
    check("flush_ready_end", in_ready, 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    early = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!in_ready) early++;
    end
    check("flush_empty_noop", early, 0);
    wait_drain("drain_flush");
`endif

    wait_drain("final_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
